// File: rtl/rand_req_issuer_pkg.sv
// rtl/rand_req_issuer_pkg.sv - shared widths and FIFO entry layout for rand_req_issuer
//
// Purpose: single source for the request field widths and the bit offsets
// used to pack/unpack a queued request {we, we_array, addr, wdata}.
package rand_req_issuer_pkg;

  localparam int RR_ADDR_W  = 26;
  localparam int RR_DATA_W  = 32;
  localparam int RR_WEA_W   = 4;
  localparam int RR_ENTRY_W = 1 + RR_WEA_W + RR_ADDR_W + RR_DATA_W;  // 63

  // Entry layout, LSB first: wdata, addr, we_array, we.
  localparam int RR_WDATA_LSB = 0;
  localparam int RR_ADDR_LSB  = RR_WDATA_LSB + RR_DATA_W;
  localparam int RR_WEA_LSB   = RR_ADDR_LSB + RR_ADDR_W;
  localparam int RR_WE_BIT    = RR_WEA_LSB + RR_WEA_W;

endpackage

// File: rtl/rr_sync_fifo.sv
// rtl/rr_sync_fifo.sv - synchronous FIFO with registered count and head read-out
//
// Purpose: command queue for rand_req_issuer. The caller guarantees that
// push_i is only asserted when count_o != DEPTH and pop_i only when
// count_o != 0.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, wdata_i   write wdata_i at the tail
//   pop_i             discard the head entry
//   head_o            current head entry (valid when count_o != 0)
//   count_o           number of stored entries, 0..DEPTH
module rr_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 63
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_i && !pop_i)      count_d = count_q + (AW+1)'(1);
    else if (!push_i && pop_i) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rand_req_issuer.sv
// rtl/rand_req_issuer.sv - client-to-DDR random-access request feeder
//
// Purpose: queues client word requests, presents them to the DDR controller
// with level-held rand_req semantics, and returns read data as one-cycle
// pulses READ_LAT cycles after each read is acknowledged.
// Optional: RAND_REQ_REFRESH_TIMER_EN enables the refresh_strobe toggle timer
// (parameter REFRESH_INTERVAL exists only in that build).
// Ports:
//   CLK_n, RST                clock, synchronous active-high reset
//   c_valid/c_ready           client request handshake
//   c_we, c_we_array, c_addr, c_wdata   client request fields
//   r_valid, r_data           read return pulse and data
//   busy                      work queued, staged or in flight
//   rand_req, rand_req_*      staged request to the controller
//   rand_req_ack              controller took the staged word
//   user_req_dataout          controller read data
//   refresh_strobe            refresh request toggle
module rand_req_issuer
  import rand_req_issuer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int READ_LAT = 6
`ifdef RAND_REQ_REFRESH_TIMER_EN
  , parameter int REFRESH_INTERVAL = 768
`endif
) (
  input  logic                 CLK_n,
  input  logic                 RST,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic                 c_we,
  input  logic [RR_WEA_W-1:0]  c_we_array,
  input  logic [RR_ADDR_W-1:0] c_addr,
  input  logic [RR_DATA_W-1:0] c_wdata,
  output logic                 r_valid,
  output logic [RR_DATA_W-1:0] r_data,
  output logic                 busy,
  output logic                 rand_req,
  output logic                 rand_req_we,
  output logic [RR_WEA_W-1:0]  rand_req_we_array,
  output logic [RR_ADDR_W-1:0] rand_req_address,
  output logic [RR_DATA_W-1:0] rand_req_datain,
  input  logic                 rand_req_ack,
  input  logic [RR_DATA_W-1:0] user_req_dataout,
  output logic                 refresh_strobe
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]         fifo_count;
  logic [RR_ENTRY_W-1:0] fifo_head;
  logic [RR_ENTRY_W-1:0] push_entry;
  logic                  push, pop, fifo_nonempty, ack_ok, read_ack;

  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [RR_WEA_W-1:0]  wea_q, wea_d;
  logic [RR_ADDR_W-1:0] addr_q, addr_d;
  logic [RR_DATA_W-1:0] wdata_q, wdata_d;
  logic [READ_LAT-1:0]  tag_q, tag_d;
  logic                 r_valid_q, r_valid_d;
  logic [RR_DATA_W-1:0] r_data_q, r_data_d;

  // Full blocks pushes even when the staging register pops the same cycle.
  assign c_ready       = !RST && (fifo_count != CW'(DEPTH));
  assign push          = c_valid && c_ready;
  assign fifo_nonempty = (fifo_count != '0);
  // An ack is only meaningful while a request is actually presented.
  assign ack_ok        = rand_req_ack && req_q;
  assign read_ack      = ack_ok && !we_q;
  assign pop           = fifo_nonempty && (!req_q || rand_req_ack);

  always_comb begin
    push_entry = '0;
    push_entry[RR_WE_BIT]                   = c_we;
    push_entry[RR_WEA_LSB +: RR_WEA_W]      = c_we_array;
    push_entry[RR_ADDR_LSB +: RR_ADDR_W]    = c_addr;
    push_entry[RR_WDATA_LSB +: RR_DATA_W]   = c_wdata;
  end

  rr_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RR_ENTRY_W)
  ) u_fifo (
    .clk_i   (CLK_n),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // Staging register: fields only move on a load, so they hold while stalled.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    wea_d   = wea_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (pop) begin
      req_d   = 1'b1;
      we_d    = fifo_head[RR_WE_BIT];
      wea_d   = fifo_head[RR_WEA_LSB +: RR_WEA_W];
      addr_d  = fifo_head[RR_ADDR_LSB +: RR_ADDR_W];
      wdata_d = fifo_head[RR_WDATA_LSB +: RR_DATA_W];
    end else if (ack_ok) begin
      req_d = 1'b0;
    end
  end

  // Tag pipe: bit k set means a read was acked k+1 edges ago.
  always_comb begin
    tag_d     = tag_q << 1;
    tag_d[0]  = read_ack;
    r_valid_d = tag_q[READ_LAT-1];
    r_data_d  = tag_q[READ_LAT-1] ? user_req_dataout : r_data_q;
  end

  always_ff @(posedge CLK_n) begin
    if (RST) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      wea_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      req_q     <= req_d;
      we_q      <= we_d;
      wea_q     <= wea_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tag_q     <= tag_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  assign rand_req          = req_q;
  assign rand_req_we       = we_q;
  assign rand_req_we_array = wea_q;
  assign rand_req_address  = addr_q;
  assign rand_req_datain   = wdata_q;
  assign r_valid           = r_valid_q;
  assign r_data            = r_data_q;
  assign busy              = !RST && (fifo_nonempty || req_q || (tag_q != '0));

`ifdef RAND_REQ_REFRESH_TIMER_EN
  localparam int RFW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [RFW-1:0] rf_cnt_q, rf_cnt_d;
  logic           rf_strobe_q, rf_strobe_d;

  always_comb begin
    rf_cnt_d    = rf_cnt_q + RFW'(1);
    rf_strobe_d = rf_strobe_q;
    if (rf_cnt_q == RFW'(REFRESH_INTERVAL - 1)) begin
      rf_cnt_d    = '0;
      rf_strobe_d = ~rf_strobe_q;
    end
  end

  always_ff @(posedge CLK_n) begin
    if (RST) begin
      rf_cnt_q    <= '0;
      rf_strobe_q <= 1'b0;
    end else begin
      rf_cnt_q    <= rf_cnt_d;
      rf_strobe_q <= rf_strobe_d;
    end
  end

  assign refresh_strobe = rf_strobe_q;
`else
  assign refresh_strobe = 1'b0;
`endif

endmodule
